par_check: RTL and testbench

Single-clock parity checker for a 4-bit data nibble (`a`..`d`) protected by one parity bit (`p`). Each valid cycle it computes the parity error flag `pec` over the five input bits and registers it. It also keeps a sticky error flag and a saturating error counter for status reporting. It sits on the receive side of a narrow serial/parallel link, after the deserializer and ahead of the consumer logic.

---
 rtl/par_check.sv | 88 ++++++++
 tb/tb_par_check.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/par_check.sv
// par_check: parity checker for a 4-bit nibble (a..d) plus one parity bit (p).
// Each valid sample produces a registered parity error flag. A sticky error
// flag and a saturating error counter are kept for status reporting.
//
// Parameters:
//   ODD_PARITY - 0: even parity (XOR of a,b,c,d,p must be 0); 1: odd parity
//   CNT_W      - error counter width
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst_n      - synchronous active-low reset
//   a,b,c,d    - data bits, a is MSB
//   p          - received parity bit
//   in_valid   - input bits valid this cycle
//   clr        - clear sticky flag and error counter
//   pec        - registered parity error flag of the last valid sample
//   pec_valid  - pec was updated this cycle
//   err_sticky - set on any error, held until clr or reset
//   err_cnt    - saturating count of detected errors
module par_check #(
    parameter bit          ODD_PARITY = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             p,
    input  logic             in_valid,
    input  logic             clr,
    output logic             pec,
    output logic             pec_valid,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    logic             x;
    logic             pec_d, pec_q;
    logic             pec_valid_d, pec_valid_q;
    logic             sticky_d, sticky_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign x = a ^ b ^ c ^ d ^ p ^ ODD_PARITY;

    always_comb begin
        pec_d       = pec_q;
        pec_valid_d = in_valid;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;

        if (clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end

        // Applied after clr so a same-cycle error wins and counts from zero.
        if (in_valid) begin
            pec_d = x;
            if (x) begin
                sticky_d = 1'b1;
                if (cnt_d != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_d + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pec_q       <= 1'b0;
            pec_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pec_q       <= pec_d;
            pec_valid_q <= pec_valid_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pec        = pec_q;
    assign pec_valid  = pec_valid_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_par_check.sv
module tb_par_check;

    logic clk = 1'b0;
    logic rst_n, a, b, c, d, p, in_valid, clr;

    logic       e_pec, e_pv, e_st;
    logic [7:0] e_cnt;
    logic       o_pec, o_pv, o_st;
    logic [7:0] o_cnt;
    logic       s_pec, s_pv, s_st;
    logic [1:0] s_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    par_check #(.ODD_PARITY(1'b0), .CNT_W(8)) u_even (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p),
        .in_valid(in_valid), .clr(clr),
        .pec(e_pec), .pec_valid(e_pv), .err_sticky(e_st), .err_cnt(e_cnt)
    );

    par_check #(.ODD_PARITY(1'b1), .CNT_W(8)) u_odd (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p),
        .in_valid(in_valid), .clr(clr),
        .pec(o_pec), .pec_valid(o_pv), .err_sticky(o_st), .err_cnt(o_cnt)
    );

    par_check #(.ODD_PARITY(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p),
        .in_valid(in_valid), .clr(clr),
        .pec(s_pec), .pec_valid(s_pv), .err_sticky(s_st), .err_cnt(s_cnt)
    );

    // Set inputs {a,b,c,d,p}, in_valid and clr, then advance one edge and settle.
    task automatic step(input logic [4:0] v, input logic vld, input logic cl);
        {a, b, c, d, p} = v;
        in_valid = vld;
        clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            {a, b, c, d, p, in_valid, clr} = 7'($urandom);
            @(posedge clk);
            #1;
        end
        checks++;
        if ({e_pec, e_pv, e_st, e_cnt, o_pec, o_pv, o_st, o_cnt, s_pec, s_pv, s_st, s_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_hold: even=%b%b%b/%0d odd=%b%b%b/%0d sat=%b%b%b/%0d, want all 0",
                     e_pec, e_pv, e_st, e_cnt, o_pec, o_pv, o_st, o_cnt, s_pec, s_pv, s_st, s_cnt);
        end
        rst_n = 1'b1;
        step(5'b10000, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        checks++;
        if ({e_pec, e_pv, e_st, e_cnt, o_pec, o_pv, o_st, o_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_release: even=%b%b%b/%0d odd=%b%b%b/%0d, want all 0",
                     e_pec, e_pv, e_st, e_cnt, o_pec, o_pv, o_st, o_cnt);
        end
    endtask

    task automatic test_exhaustive();
        int ones;
        logic exp_pec;
        for (int v = 0; v < 32; v++) begin
            ones = 0;
            for (int k = 0; k < 5; k++) ones += (v >> k) & 1;
            exp_pec = (ones % 2) == 1;
            step(5'(v), 1'b1, 1'b0);
            checks++;
            if (e_pec !== exp_pec || e_pv !== 1'b1) begin
                errors++;
                $display("FAIL even_sweep v=%05b: pec=%b pv=%b, want pec=%b pv=1", 5'(v), e_pec, e_pv,
                         exp_pec);
            end
            checks++;
            if (o_pec !== !exp_pec) begin
                errors++;
                $display("FAIL odd_sweep v=%05b: pec=%b, want %b", 5'(v), o_pec, !exp_pec);
            end
        end
        // 16 of 32 patterns err for each parity sense; the 2-bit counter pins at 3.
        checks++;
        if (e_cnt !== 8'd16 || o_cnt !== 8'd16 || s_cnt !== 2'd3 || e_st !== 1'b1) begin
            errors++;
            $display("FAIL sweep_counts: even=%0d odd=%0d sat=%0d sticky=%b, want 16 16 3 1",
                     e_cnt, o_cnt, s_cnt, e_st);
        end
    endtask

    task automatic test_examples();
        step(5'b10111, 1'b1, 1'b0);
        checks++;
        if (e_pec !== 1'b0) begin
            errors++;
            $display("FAIL even_10111: pec=%b, want 0", e_pec);
        end
        step(5'b10000, 1'b1, 1'b0);
        checks++;
        if (e_pec !== 1'b1 || o_pec !== 1'b0) begin
            errors++;
            $display("FAIL ex_10000: even pec=%b odd pec=%b, want 1 0", e_pec, o_pec);
        end
        step(5'b00000, 1'b1, 1'b0);
        checks++;
        if (e_pec !== 1'b0 || o_pec !== 1'b1) begin
            errors++;
            $display("FAIL ex_00000: even pec=%b odd pec=%b, want 0 1", e_pec, o_pec);
        end
    endtask

    task automatic test_sticky_counter();
        step(5'b00000, 1'b0, 1'b1);
        checks++;
        if (e_st !== 1'b0 || e_cnt !== 8'd0 || s_cnt !== 2'd0) begin
            errors++;
            $display("FAIL clr_idle: sticky=%b cnt=%0d sat=%0d, want 0 0 0", e_st, e_cnt, s_cnt);
        end
        for (int i = 0; i < 3; i++) step(5'b01000, 1'b1, 1'b0);
        step(5'b11000, 1'b1, 1'b0);
        step(5'b00011, 1'b1, 1'b0);
        checks++;
        if (e_st !== 1'b1 || e_cnt !== 8'd3 || e_pec !== 1'b0) begin
            errors++;
            $display("FAIL three_errors: sticky=%b cnt=%0d pec=%b, want 1 3 0", e_st, e_cnt, e_pec);
        end
        step(5'b00000, 1'b0, 1'b1);
        checks++;
        if (e_st !== 1'b0 || e_cnt !== 8'd0 || e_pec !== 1'b0) begin
            errors++;
            $display("FAIL clr_pulse: sticky=%b cnt=%0d pec=%b, want 0 0 0", e_st, e_cnt, e_pec);
        end
        step(5'b00000, 1'b1, 1'b0);
        step(5'b00000, 1'b1, 1'b0);
        step(5'b00001, 1'b1, 1'b0);
        checks++;
        if (e_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pre_clr_err: cnt=%0d, want 1", e_cnt);
        end
        step(5'b00001, 1'b1, 1'b1);
        checks++;
        if (e_st !== 1'b1 || e_cnt !== 8'd1 || e_pec !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_err: sticky=%b cnt=%0d pec=%b, want 1 1 1", e_st, e_cnt, e_pec);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(5'b00000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(5'b00100, 1'b1, 1'b0);
            checks++;
            if (s_cnt !== want[i] || e_cnt !== 8'(i + 1)) begin
                errors++;
                $display("FAIL saturate[%0d]: sat=%0d even=%0d, want %0d %0d", i, s_cnt, e_cnt,
                         want[i], i + 1);
            end
        end
    endtask

    task automatic test_gating();
        step(5'b00000, 1'b1, 1'b0);
        step(5'b10000, 1'b0, 1'b0);
        checks++;
        if (e_pec !== 1'b0 || e_pv !== 1'b0 || e_cnt !== 8'd5) begin
            errors++;
            $display("FAIL gate_hold0: pec=%b pv=%b cnt=%0d, want 0 0 5", e_pec, e_pv, e_cnt);
        end
        step(5'b11100, 1'b1, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        step(5'b00010, 1'b0, 1'b0);
        checks++;
        if (e_pec !== 1'b1 || e_pv !== 1'b0 || e_cnt !== 8'd6 || s_cnt !== 2'd3) begin
            errors++;
            $display("FAIL gate_hold1: pec=%b pv=%b cnt=%0d sat=%0d, want 1 0 6 3", e_pec, e_pv,
                     e_cnt, s_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        rst_n = 1'b0;
        step(5'b10000, 1'b1, 1'b1);
        checks++;
        if ({e_pec, e_pv, e_st, e_cnt, s_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset: pec=%b pv=%b sticky=%b cnt=%0d sat=%0d, want all 0", e_pec,
                     e_pv, e_st, e_cnt, s_cnt);
        end
        rst_n = 1'b1;
        step(5'b10000, 1'b1, 1'b0);
        checks++;
        if (e_pec !== 1'b1 || e_pv !== 1'b1 || e_st !== 1'b1 || e_cnt !== 8'd1) begin
            errors++;
            $display("FAIL post_reset: pec=%b pv=%b sticky=%b cnt=%0d, want 1 1 1 1", e_pec, e_pv,
                     e_st, e_cnt);
        end
        // Back-to-back samples: each reported exactly one edge later.
        step(5'b00000, 1'b1, 1'b0);
        checks++;
        if (e_pec !== 1'b0 || e_pv !== 1'b1 || e_cnt !== 8'd1) begin
            errors++;
            $display("FAIL back_to_back: pec=%b pv=%b cnt=%0d, want 0 1 1", e_pec, e_pv, e_cnt);
        end
    endtask

    initial begin
        {rst_n, a, b, c, d, p, in_valid, clr} = '0;
        test_reset();
        test_exhaustive();
        test_examples();
        test_sticky_counter();
        test_saturation();
        test_gating();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
